// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Shares a single-port data memory between two requesters: port 0
//   (processor load/store path) and port 1 (I/O / DMA-style agent).
//   One access is granted per cycle. Plain contention alternates
//   between the ports (round-robin). A bounded lock lets a port keep
//   ownership for up to LOCK_MAX consecutive grants so it can run an
//   atomic read-modify-write sequence.
//
// Ports
//   clock_in, reset_in      : rising-edge clock; asynchronous active-low reset
//   reqN_in / ackN_out      : request, held with its fields until acknowledged;
//                             the ack is combinational (access done this cycle)
//   weN_in, lockN_in        : write (1) / read (0); keep ownership for next access
//   addrN_in, dataN_in      : access address and write data
//   rdataN_out, rvalidN_out : registered read data and its one-cycle valid pulse
//   mem_data_out, mem_address_out, mem_wr_out : drive the memory
//   mem_data_in             : asynchronous read data from the memory
module data_memory_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11,
  parameter int LOCK_MAX      = 4
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     req0_in,
  input  logic                     we0_in,
  input  logic                     lock0_in,
  input  logic [ADDRESS_WIDTH-1:0] addr0_in,
  input  logic [DATA_WIDTH-1:0]    data0_in,
  output logic                     ack0_out,
  output logic [DATA_WIDTH-1:0]    rdata0_out,
  output logic                     rvalid0_out,
  input  logic                     req1_in,
  input  logic                     we1_in,
  input  logic                     lock1_in,
  input  logic [ADDRESS_WIDTH-1:0] addr1_in,
  input  logic [DATA_WIDTH-1:0]    data1_in,
  output logic                     ack1_out,
  output logic [DATA_WIDTH-1:0]    rdata1_out,
  output logic                     rvalid1_out,
  output logic [DATA_WIDTH-1:0]    mem_data_out,
  output logic [ADDRESS_WIDTH-1:0] mem_address_out,
  output logic                     mem_wr_out,
  input  logic [DATA_WIDTH-1:0]    mem_data_in
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
  localparam logic [CW-1:0] ONE_C      = CW'(1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  // State registers
  logic                  last_r;
  owner_t                owner_r;
  logic [CW-1:0]         lock_count_r;
  logic [DATA_WIDTH-1:0] rdata0_r;
  logic [DATA_WIDTH-1:0] rdata1_r;
  logic                  rvalid0_r;
  logic                  rvalid1_r;

  // Grant decision
  logic grant_valid_s;
  logic grant_port_s;
  logic grant_locked_s;   // grant came from holding an existing lock
  logic grant_we_s;
  logic grant_lock_s;

  // Next-state values
  logic                  last_n_s;
  owner_t                owner_n_s;
  logic [CW-1:0]         lock_count_n_s;
  logic [DATA_WIDTH-1:0] rdata0_n_s;
  logic [DATA_WIDTH-1:0] rdata1_n_s;
  logic                  rvalid0_n_s;
  logic                  rvalid1_n_s;

  // Grant selection: held lock first, then round-robin, then single requester.
  // Nothing is granted while reset is asserted so no write reaches memory.
  always_comb begin
    grant_valid_s  = 1'b0;
    grant_port_s   = 1'b0;
    grant_locked_s = 1'b0;
    if (!reset_in) begin
      grant_valid_s = 1'b0;
    end else if ((owner_r == OWN_P0) && req0_in && lock0_in && (lock_count_r < LOCK_MAX_C)) begin
      grant_valid_s  = 1'b1;
      grant_port_s   = 1'b0;
      grant_locked_s = 1'b1;
    end else if ((owner_r == OWN_P1) && req1_in && lock1_in && (lock_count_r < LOCK_MAX_C)) begin
      grant_valid_s  = 1'b1;
      grant_port_s   = 1'b1;
      grant_locked_s = 1'b1;
    end else if (req0_in && req1_in) begin
      grant_valid_s = 1'b1;
      grant_port_s  = ~last_r;
    end else if (req0_in) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b0;
    end else if (req1_in) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
    end
  end

  // Memory-side multiplexing and acknowledges for the granted port
  always_comb begin
    mem_address_out = '0;
    mem_data_out    = '0;
    mem_wr_out      = 1'b0;
    ack0_out        = 1'b0;
    ack1_out        = 1'b0;
    grant_we_s      = 1'b0;
    grant_lock_s    = 1'b0;
    if (grant_valid_s) begin
      if (grant_port_s) begin
        mem_address_out = addr1_in;
        mem_data_out    = data1_in;
        grant_we_s      = we1_in;
        grant_lock_s    = lock1_in;
        ack1_out        = 1'b1;
      end else begin
        mem_address_out = addr0_in;
        mem_data_out    = data0_in;
        grant_we_s      = we0_in;
        grant_lock_s    = lock0_in;
        ack0_out        = 1'b1;
      end
      mem_wr_out = grant_we_s;
    end else begin
      mem_wr_out = 1'b0;
    end
  end

  // Next-state: round-robin pointer, lock ownership and read-data capture
  always_comb begin
    last_n_s       = last_r;
    owner_n_s      = OWN_NONE;
    lock_count_n_s = '0;
    rdata0_n_s     = rdata0_r;
    rdata1_n_s     = rdata1_r;
    rvalid0_n_s    = 1'b0;
    rvalid1_n_s    = 1'b0;
    if (grant_valid_s) begin
      last_n_s = grant_port_s;
      if (!grant_we_s) begin
        if (grant_port_s) begin
          rdata1_n_s  = mem_data_in;
          rvalid1_n_s = 1'b1;
        end else begin
          rdata0_n_s  = mem_data_in;
          rvalid0_n_s = 1'b1;
        end
      end else begin
        rvalid0_n_s = 1'b0;
      end
      // A fresh lock (or one re-won after exhaustion) restarts the count at 1
      if (grant_lock_s) begin
        owner_n_s      = grant_port_s ? OWN_P1 : OWN_P0;
        lock_count_n_s = grant_locked_s ? (lock_count_r + ONE_C) : ONE_C;
      end else begin
        owner_n_s      = OWN_NONE;
        lock_count_n_s = '0;
      end
    end else begin
      owner_n_s = OWN_NONE;
    end
  end

  // State register; port 0 wins the first tie after reset (last = 1)
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      last_r       <= 1'b1;
      owner_r      <= OWN_NONE;
      lock_count_r <= '0;
      rdata0_r     <= '0;
      rdata1_r     <= '0;
      rvalid0_r    <= 1'b0;
      rvalid1_r    <= 1'b0;
    end else begin
      last_r       <= last_n_s;
      owner_r      <= owner_n_s;
      lock_count_r <= lock_count_n_s;
      rdata0_r     <= rdata0_n_s;
      rdata1_r     <= rdata1_n_s;
      rvalid0_r    <= rvalid0_n_s;
      rvalid1_r    <= rvalid1_n_s;
    end
  end

  assign rdata0_out  = rdata0_r;
  assign rdata1_out  = rdata1_r;
  assign rvalid0_out = rvalid0_r;
  assign rvalid1_out = rvalid1_r;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter
//   Directed bench for data_memory_arbiter with a behavioural memory
//   (asynchronous read, write on rising edge). Inputs change on the
//   falling edge; combinational outputs are sampled 1 ns later and
//   registered outputs 1 ns after the rising edge.
module tb_data_memory_arbiter;

  localparam int DW = 16;
  localparam int AW = 11;

  logic          clock_in;
  logic          reset_in;
  logic          req0_in, we0_in, lock0_in;
  logic [AW-1:0] addr0_in;
  logic [DW-1:0] data0_in;
  logic          ack0_out, rvalid0_out;
  logic [DW-1:0] rdata0_out;
  logic          req1_in, we1_in, lock1_in;
  logic [AW-1:0] addr1_in;
  logic [DW-1:0] data1_in;
  logic          ack1_out, rvalid1_out;
  logic [DW-1:0] rdata1_out;
  logic [DW-1:0] mem_data_out;
  logic [AW-1:0] mem_address_out;
  logic          mem_wr_out;
  logic [DW-1:0] mem_data_in;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks;
  int errors;

  data_memory_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LOCK_MAX(4)) dut (
    .clock_in(clock_in), .reset_in(reset_in),
    .req0_in(req0_in), .we0_in(we0_in), .lock0_in(lock0_in),
    .addr0_in(addr0_in), .data0_in(data0_in),
    .ack0_out(ack0_out), .rdata0_out(rdata0_out), .rvalid0_out(rvalid0_out),
    .req1_in(req1_in), .we1_in(we1_in), .lock1_in(lock1_in),
    .addr1_in(addr1_in), .data1_in(data1_in),
    .ack1_out(ack1_out), .rdata1_out(rdata1_out), .rvalid1_out(rvalid1_out),
    .mem_data_out(mem_data_out), .mem_address_out(mem_address_out),
    .mem_wr_out(mem_wr_out), .mem_data_in(mem_data_in)
  );

  // Clock
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // Behavioural memory
  assign mem_data_in = mem[mem_address_out];
  always @(posedge clock_in) begin
    if (mem_wr_out) mem[mem_address_out] <= mem_data_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req0_in = req; we0_in = we; lock0_in = lock; addr0_in = addr; data0_in = data;
  endtask

  task automatic drive1(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req1_in = req; we1_in = we; lock1_in = lock; addr1_in = addr; data1_in = data;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h0000;
    mem[11'h005] = 16'hBEEF;
    mem[11'h006] = 16'h1234;

    // Reset held with both ports requesting writes
    reset_in = 1'b0;
    drive0(1'b1, 1'b1, 1'b0, 11'h020, 16'hAAAA);
    drive1(1'b1, 1'b1, 1'b0, 11'h021, 16'h5555);
    repeat (2) @(posedge clock_in);
    #1;
    chk("rst_mem_wr", 32'(mem_wr_out), 32'h0);
    chk("rst_ack0", 32'(ack0_out), 32'h0);
    chk("rst_ack1", 32'(ack1_out), 32'h0);
    chk("rst_rvalid0", 32'(rvalid0_out), 32'h0);
    chk("rst_rvalid1", 32'(rvalid1_out), 32'h0);
    chk("rst_rdata0", 32'(rdata0_out), 32'h0);
    chk("rst_rdata1", 32'(rdata1_out), 32'h0);
    chk("rst_no_write", 32'(mem[11'h020]), 32'h0);

    // Release: both read, port 0 must win first
    @(negedge clock_in);
    reset_in = 1'b1;
    drive0(1'b1, 1'b0, 1'b0, 11'h005, 16'h0000);
    drive1(1'b1, 1'b0, 1'b0, 11'h006, 16'h0000);
    #1;
    chk("first_ack0", 32'(ack0_out), 32'h1);
    chk("first_ack1", 32'(ack1_out), 32'h0);
    chk("first_addr", 32'(mem_address_out), 32'h005);
    @(posedge clock_in); #1;
    chk("first_rvalid0", 32'(rvalid0_out), 32'h1);
    chk("first_rdata0", 32'(rdata0_out), 32'hBEEF);

    // Single read by port 1 at 0x005
    @(negedge clock_in);
    drive0(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    drive1(1'b1, 1'b0, 1'b0, 11'h005, 16'h0000);
    #1;
    chk("single_ack1", 32'(ack1_out), 32'h1);
    chk("single_ack0", 32'(ack0_out), 32'h0);
    chk("single_wr", 32'(mem_wr_out), 32'h0);
    @(posedge clock_in); #1;
    chk("single_rvalid1", 32'(rvalid1_out), 32'h1);
    chk("single_rdata1", 32'(rdata1_out), 32'hBEEF);
    chk("single_rvalid0", 32'(rvalid0_out), 32'h0);

    // Contention: last=1 so port 0 write goes first, then port 1 read
    @(negedge clock_in);
    drive0(1'b1, 1'b1, 1'b0, 11'h010, 16'h1111);
    drive1(1'b1, 1'b0, 1'b0, 11'h010, 16'h0000);
    #1;
    chk("cont1_ack0", 32'(ack0_out), 32'h1);
    chk("cont1_ack1", 32'(ack1_out), 32'h0);
    chk("cont1_wr", 32'(mem_wr_out), 32'h1);
    chk("cont1_wdata", 32'(mem_data_out), 32'h1111);
    chk("cont1_addr", 32'(mem_address_out), 32'h010);
    @(posedge clock_in); #1;
    chk("cont1_no_rvalid0", 32'(rvalid0_out), 32'h0);
    chk("cont1_mem", 32'(mem[11'h010]), 32'h1111);

    @(negedge clock_in);
    drive0(1'b1, 1'b1, 1'b0, 11'h011, 16'h2222);
    #1;
    chk("cont2_ack1", 32'(ack1_out), 32'h1);
    chk("cont2_ack0", 32'(ack0_out), 32'h0);
    chk("cont2_wr", 32'(mem_wr_out), 32'h0);
    @(posedge clock_in); #1;
    chk("cont2_rvalid1", 32'(rvalid1_out), 32'h1);
    chk("cont2_rdata1", 32'(rdata1_out), 32'h1111);

    @(negedge clock_in);
    drive1(1'b1, 1'b0, 1'b0, 11'h011, 16'h0000);
    #1;
    chk("cont3_ack0", 32'(ack0_out), 32'h1);
    chk("cont3_ack1", 32'(ack1_out), 32'h0);
    @(posedge clock_in); #1;
    chk("cont3_rvalid1", 32'(rvalid1_out), 32'h0);

    @(negedge clock_in);
    #1;
    chk("cont4_ack1", 32'(ack1_out), 32'h1);
    chk("cont4_ack0", 32'(ack0_out), 32'h0);
    @(posedge clock_in); #1;
    chk("cont4_rdata1", 32'(rdata1_out), 32'h2222);

    // Lock bound: port 0 locks, port 1 waits exactly 4 grants
    @(negedge clock_in);
    drive0(1'b1, 1'b0, 1'b1, 11'h005, 16'h0000);
    drive1(1'b1, 1'b0, 1'b0, 11'h006, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("lock_ack0_%0d", k), 32'(ack0_out), 32'h1);
      chk($sformatf("lock_ack1_%0d", k), 32'(ack1_out), 32'h0);
      @(posedge clock_in); #1;
      chk($sformatf("lock_rdata0_%0d", k), 32'(rdata0_out), 32'hBEEF);
      @(negedge clock_in);
    end
    #1;
    chk("lock_exhaust_ack1", 32'(ack1_out), 32'h1);
    chk("lock_exhaust_ack0", 32'(ack0_out), 32'h0);
    @(posedge clock_in); #1;
    chk("lock_exhaust_rdata1", 32'(rdata1_out), 32'h1234);
    chk("lock_exhaust_rvalid0", 32'(rvalid0_out), 32'h0);

    // Lock release after 2 locked grants: port 1 wins the next cycle
    @(negedge clock_in);
    #1;
    chk("rel1_ack0", 32'(ack0_out), 32'h1);
    @(negedge clock_in);
    #1;
    chk("rel2_ack0", 32'(ack0_out), 32'h1);
    @(negedge clock_in);
    lock0_in = 1'b0;
    #1;
    chk("rel3_ack1", 32'(ack1_out), 32'h1);
    chk("rel3_ack0", 32'(ack0_out), 32'h0);

    // Exhaustion with other port idle: owner keeps being granted
    @(negedge clock_in);
    drive0(1'b1, 1'b0, 1'b1, 11'h006, 16'h0000);
    drive1(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("solo_ack0_%0d", k), 32'(ack0_out), 32'h1);
      @(negedge clock_in);
    end

    // Asynchronous reset mid-lock with a read just completed
    drive0(1'b1, 1'b0, 1'b1, 11'h005, 16'h0000);
    @(posedge clock_in); #1;
    chk("mid_rvalid0_pre", 32'(rvalid0_out), 32'h1);
    #1;
    reset_in = 1'b0;
    drive0(1'b1, 1'b1, 1'b1, 11'h030, 16'h7777);
    #1;
    chk("mid_rvalid0", 32'(rvalid0_out), 32'h0);
    chk("mid_rdata0", 32'(rdata0_out), 32'h0);
    chk("mid_wr", 32'(mem_wr_out), 32'h0);
    chk("mid_ack0", 32'(ack0_out), 32'h0);
    @(posedge clock_in); #1;
    chk("mid_no_write", 32'(mem[11'h030]), 32'h0);

    // Release with contention: port 0 first again
    @(negedge clock_in);
    reset_in = 1'b1;
    drive0(1'b1, 1'b0, 1'b0, 11'h006, 16'h0000);
    drive1(1'b1, 1'b0, 1'b0, 11'h005, 16'h0000);
    #1;
    chk("post_ack0", 32'(ack0_out), 32'h1);
    chk("post_ack1", 32'(ack1_out), 32'h0);
    @(posedge clock_in); #1;
    chk("post_rdata0", 32'(rdata0_out), 32'h1234);

    @(negedge clock_in);
    drive0(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    drive1(1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    #1;
    chk("idle_addr", 32'(mem_address_out), 32'h0);
    chk("idle_ack1", 32'(ack1_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter that shares the single-port data memory between two requesters: port 0 (processor load/store path) and port 1 (I/O / DMA-style agent). It selects one requester per cycle with round-robin fairness and drives the memory's write data, address and write-enable lines. It registers read data back to the winner. An optional bounded lock keeps ownership for atomic read-modify-write sequences.

## Interface
- DATA_WIDTH, 16, memory word width
- ADDRESS_WIDTH, 11, memory address width
- LOCK_MAX, 4, max consecutive locked grants to one port (>=1)

- clock_in  input  1  single clock, rising edge
- reset_in  input  1  asynchronous, active-low reset
- reqN_in  input  1  access request, N in {0,1}; held with its fields until ackN_out
- weN_in  input  1  1 = write, 0 = read
- lockN_in  input  1  request to keep ownership for the next access
- addrN_in  input  ADDRESS_WIDTH  access address
- dataN_in  input  DATA_WIDTH  write data
- ackN_out  output  1  combinational; access performed this cycle
- rdataN_out  output  DATA_WIDTH  registered read data
- rvalidN_out  output  1  registered; rdataN_out valid this cycle (one-cycle pulse)
- mem_data_out  output  DATA_WIDTH  to memory write data
- mem_address_out  output  ADDRESS_WIDTH  to memory address
- mem_wr_out  output  1  to memory write enable
- mem_data_in  input  DATA_WIDTH  from memory (asynchronous read data)

## Operation
- State registers: last (last granted port, 1 bit), owner (NONE/P0/P1), lock_count ($clog2(LOCK_MAX+1) bits), rdata0/1, rvalid0/1.
- Grant decision (combinational, per cycle, priority order):
  1. If owner==Pk, reqk_in=1, lockk_in=1 and lock_count<LOCK_MAX: grant k.
  2. Otherwise, if both request: grant the port != last.
  3. Otherwise, if one requests: grant it.
  4. Otherwise: no grant.
- Locked ownership drops the moment the owner deasserts req or lock. Other port is then eligible the same cycle.
- Granted port g: mem_address_out=addrg_in, mem_data_out=datag_in, mem_wr_out=weg_in, ackg_out=1. Other ack=0.
- No grant: mem_address_out=0, mem_data_out=0, mem_wr_out=0, both acks 0.
- While reset_in=0: no grant, mem_wr_out=0. No write may reach memory during reset.
- Posedge with grant g:
  - last<=g.
  - If g was a read: rdatag<=mem_data_in, rvalidg<=1.
  - If lockg_in=1: owner<=g; lock_count<=lock_count+1 when the grant came from rule 1, else 1.
  - If lockg_in=0: owner<=NONE, lock_count<=0.
- Posedge without grant: owner<=NONE, lock_count<=0, last unchanged.
- rvalid of any port not completing a read this edge <=0. rdata holds its last value.
- Lock exhaustion: after LOCK_MAX consecutive locked grants, rule 1 fails and normal arbitration applies. With last==owner, the other port wins if requesting. If it is not requesting, the owner is re-granted via rule 3 and lock_count restarts at 1 (when lock held).
- Writes produce no rvalid.

## Timing
- Reset values: last=1 (port 0 wins first tie), owner=NONE, lock_count=0, rdata0/1=0, rvalid0/1=0. ack/mem outputs are 0 per the combinational rules.
- Access latency: ack in the request cycle if granted. Write committed at that cycle's rising edge.
- Read data: rvalid/rdata one cycle after ack.
- Worst-case wait without lock: 1 cycle. With the other port locking: LOCK_MAX cycles.
- Back-to-back: a port may be granted every cycle when uncontested.
- Reset mid-operation: all state cleared asynchronously. A pending rvalid is lost. Requesters re-arbitrate after release, with port 0 first on contention.

## Test plan
- Reset: hold reset_in=0 with req0/req1 writes asserted -> mem_wr_out=0, acks 0, rvalid0/1=0, rdata=0. After release, both request -> ack0 first.
- Single read: port 1 reads addr 0x005 holding 0xBEEF -> ack1_out same cycle; next cycle rvalid1_out=1, rdata1_out=0xBEEF, rvalid0_out=0.
- Contention: both request continuously (port 0 writes 0x1111 @0x010, port 1 reads) -> grants alternate 0,1,0,1. Port 1 reads 0x1111 after port 0's write commits.
- Lock bound, LOCK_MAX=4: port 0 holds req+lock, port 1 requests -> exactly 4 consecutive ack0, then ack1.
- Lock release: port 0 drops lock0_in after 2 locked grants while port 1 requests -> ack1 the next cycle.
- Async reset mid-lock: assert reset_in low between edges during a locked read -> rvalid0_out clears immediately, owner=NONE, no write issued.
